alu_control_seq: RTL
====================

// Module: alu_control_seq
// PURPOSE
//  Parametrised ALU control unit with registered decode and multiply/divide sequencing.
//  - Decodes aluop/func into the ALU operation code (same encoding family as the current ALU
//    control), extended with SLT, NOR, SLL and SRL.
//  - Sequences the multi-cycle MULT/DIV unit through a start/busy/done handshake.
//  - Sits between the main control decoder and the ALU/HI-LO datapath.
//  - Holds the register stage feeding the ALU.
// PARAMETERS
//  ALUOP_W     2   width of aluop from the main decoder
//  FUNC_W      6   width of the R-type func field
//  OP_W        4   width of aluopration
//  MUL_CYCLES  4   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES  32  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  in_valid     in   1        aluop/func valid this cycle
//  in_ready     out  1        unit can accept; = (state==IDLE)
//  aluop        in   ALUOP_W  class from main decoder
//  func         in   FUNC_W   R-type function field
//  aluopration  out  OP_W     registered ALU operation code
//  illegal      out  1        registered; unknown func under aluop=10
//  md_start     out  1        1-cycle pulse: start MULT/DIV unit
//  md_signed    out  1        registered; 1 = MULT/DIV, 0 = MULTU/DIVU
//  md_is_div    out  1        registered; 1 = divide, 0 = multiply
//  md_busy      out  1        high while MUL or DIV is in progress
//  md_done      out  1        1-cycle pulse when the result is ready
//  hilo_we      out  1        1-cycle pulse, coincident with md_done
// BEHAVIOUR
//  Reset
//  - Every output is 0; state = IDLE; counter = 0.
//  - in_ready reads 0 during rst and 1 on the first cycle after rst.
//  Decode (accept = in_valid & in_ready; latency 1 cycle)
//  - aluop=00 -> 0010 (add).
//  - aluop=01 -> 0110 (sub).
//  - aluop=11 -> 1000.
//  - aluop=10, by func:
//    - 100000 -> 0010 (add);  100010 -> 0110 (sub).
//    - 100100 -> 0000 (and);  100101 -> 0001 (or).
//    - 101010 -> 0111 (slt);  100111 -> 1100 (nor).
//    - 000000 -> 1001 (sll);  000010 -> 1010 (srl).
//    - 011000 / 011001 -> MULT / MULTU.
//    - 011010 / 011011 -> DIV / DIVU.
//    - any other func -> aluopration = 1111, illegal = 1.
//  - The decode is fully combinational on all inputs; no X is ever driven.
//  - With no accept, aluopration and illegal hold their values.
//  FSM states: IDLE, MUL, DIV, DONE
//  - IDLE -> MUL/DIV on accept of a mult/div func.
//    - md_start = 1 for that one cycle.
//    - md_signed and md_is_div are latched.
//    - counter is loaded with MUL_CYCLES-1 or DIV_CYCLES-1.
//    - aluopration = 0000.
//  - MUL/DIV: md_busy = 1 and in_ready = 0.
//    - counter decrements each cycle.
//    - At counter==0 -> DONE.
//    - Busy length is exactly N cycles after the accept cycle.
//  - DONE: md_done = hilo_we = 1 for 1 cycle; in_ready = 0; -> IDLE.
//  - IDLE with no accept, or with a non-md accept: stay in IDLE.
//  Boundary conditions
//  - in_valid while busy: ignored; no decode update and no queueing.
//  - Reset mid-operation: abort immediately, no md_done, all outputs 0.
//  - MUL_CYCLES=1: the MUL state lasts one cycle, then DONE.
//  - Counter width is $clog2(max(MUL_CYCLES,DIV_CYCLES))+1 bits; it never wraps.
// STRUCTURE
//  - Package alu_ctrl_pkg holds:
//    - ALUOP_* and FUNC_* constants;
//    - ALU_ADD/SUB/AND/OR/SLT/NOR/SLL/SRL/ILL operation codes;
//    - the state encoding IDLE=0, MUL=1, DIV=2, DONE=3.
//  - Sub-module alu_func_decode: pure combinational (aluop,func) -> {op, illegal, is_md, signed, div}.
//  - The top level holds the FSM, the down-counter and the output registers.
// TESTING
//  1. rst=1 for 3 cycles: all outputs 0; release -> in_ready=1 next cycle.
//  2. aluop=10, func=101010, in_valid: aluopration=0111 one cycle later; holds after in_valid drops.
//  3. aluop=10, func=111111: aluopration=1111, illegal=1.
//     Then aluop=00: aluopration=0010, illegal=0.
//  4. MULT accepted at cycle t:
//     - md_start at t+1; md_busy at t+1..t+4;
//     - md_done = hilo_we at t+5; in_ready=1 at t+6; md_signed=1.
//  5. DIVU with in_valid held and func changed mid-busy:
//     - the changed input is ignored;
//     - md_done 33 cycles after the accept; md_is_div=1, md_signed=0.
//  6. DIV started, rst asserted at busy cycle 10: next cycle all outputs 0, state IDLE, no md_done.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control unit: aluop classes, R-type func codes,
// ALU operation codes and the multiply/divide sequencer state encoding.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_NOR   = 6'b100111;
  localparam logic [5:0] FUNC_SLL   = 6'b000000;
  localparam logic [5:0] FUNC_SRL   = 6'b000010;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_IMM = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_ILL = 4'b1111;
  // The ALU itself idles while the MULT/DIV unit owns the operation.
  localparam logic [3:0] ALU_MD  = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// Pure combinational (aluop, func) decode into ALU op code, illegal flag and
// MULT/DIV classification. Every input pattern maps to a defined output.
module alu_func_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int FUNC_W  = 6
) (
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNC_W-1:0]  func,
  output logic [3:0]         op,
  output logic               illegal,
  output logic               is_md,
  output logic               md_signed,
  output logic               md_div
);

  logic [1:0] aluop2;
  logic [5:0] func6;

  assign aluop2 = 2'(aluop);
  assign func6  = 6'(func);

  always_comb begin
    op        = ALU_ADD;
    illegal   = 1'b0;
    is_md     = 1'b0;
    md_signed = 1'b0;
    md_div    = 1'b0;
    case (aluop2)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_IMM: op = ALU_IMM;
      default: begin
        case (func6)
          FUNC_ADD: op = ALU_ADD;
          FUNC_SUB: op = ALU_SUB;
          FUNC_AND: op = ALU_AND;
          FUNC_OR:  op = ALU_OR;
          FUNC_SLT: op = ALU_SLT;
          FUNC_NOR: op = ALU_NOR;
          FUNC_SLL: op = ALU_SLL;
          FUNC_SRL: op = ALU_SRL;
          FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: begin
            op        = ALU_MD;
            is_md     = 1'b1;
            md_signed = ~func6[0];
            md_div    = func6[1];
          end
          default: begin
            op      = ALU_ILL;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control with registered decode and MULT/DIV start/busy/done sequencing.
// All outputs are registered; new work is taken only while in_ready is high.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 2,
  parameter int FUNC_W     = 6,
  parameter int OP_W       = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNC_W-1:0]  func,
  output logic [OP_W-1:0]    aluopration,
  output logic               illegal,
  output logic               md_start,
  output logic               md_signed,
  output logic               md_is_div,
  output logic               md_busy,
  output logic               md_done,
  output logic               hilo_we
);

  localparam int CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [3:0] dec_op;
  logic       dec_illegal;
  logic       dec_is_md;
  logic       dec_signed;
  logic       dec_div;

  alu_func_decode #(
    .ALUOP_W (ALUOP_W),
    .FUNC_W  (FUNC_W)
  ) u_decode (
    .aluop     (aluop),
    .func      (func),
    .op        (dec_op),
    .illegal   (dec_illegal),
    .is_md     (dec_is_md),
    .md_signed (dec_signed),
    .md_div    (dec_div)
  );

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             illegal_q, illegal_d;
  logic             in_ready_q, in_ready_d;
  logic             start_q, start_d;
  logic             signed_q, signed_d;
  logic             is_div_q, is_div_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    signed_d  = signed_q;
    is_div_d  = is_div_q;
    start_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = OP_W'(dec_op);
          illegal_d = dec_illegal;
          if (dec_is_md) begin
            state_d  = dec_div ? DIV : MUL;
            cnt_d    = dec_div ? DIV_LOAD : MUL_LOAD;
            start_d  = 1'b1;
            signed_d = dec_signed;
            is_div_d = dec_div;
          end
        end
      end
      MUL, DIV: begin
        // Counter stops at zero; the transition to DONE ends the busy window.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d == MUL) || (state_d == DIV);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      illegal_q  <= 1'b0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      signed_q   <= 1'b0;
      is_div_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      illegal_q  <= illegal_d;
      in_ready_q <= in_ready_d;
      start_q    <= start_d;
      signed_q   <= signed_d;
      is_div_q   <= is_div_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign aluopration = op_q;
  assign illegal     = illegal_q;
  assign md_start    = start_q;
  assign md_signed   = signed_q;
  assign md_is_div   = is_div_q;
  assign md_busy     = busy_q;
  assign md_done     = done_q;
  assign hilo_we     = done_q;

endmodule
